lcd_cmd_sequencer: RTL and testbench

//  Script-driven command master for the LCD_CTRL image-processing core.
//  - On a start pulse, fetches 5-bit entries from a command ROM (CROM) and issues each cmd to LCD_CTRL.
//  - Obeys LCD busy; after a WRITE (cmd 0) it waits for LCD done.
//  - Skips illegal codes, then pulses seq_done.
//  - Sits between the host/testbench and LCD_CTRL; replaces hand-driven cmd/cmd_valid.

---
 rtl/lcd_cmd_sequencer.sv | 172 +++++++++++++++++
 tb/tb_lcd_cmd_sequencer.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_cmd_sequencer.sv
// lcd_cmd_sequencer
//   Script-driven command master for the LCD_CTRL image-processing core. A start pulse
//   walks a command ROM from entry 0. Each legal entry is issued to LCD_CTRL as a
//   one-cycle lcd_valid strobe. Illegal codes are counted and skipped. After a WRITE
//   (cmd 0) the sequencer waits for lcd_done. A one-cycle seq_done pulse marks the end
//   of the script.
//
// Ports
//   clk         clock, rising edge
//   reset       asynchronous active-low reset
//   start       1-cycle run request, ignored while seq_busy
//   crom_rd     CROM read enable
//   crom_a      CROM address (current script pointer)
//   crom_q      CROM data, valid the cycle after crom_rd; [4]=last, [3:0]=cmd
//   lcd_cmd     command to LCD_CTRL, held from LATCH through SETTLE
//   lcd_valid   command strobe, never asserted while lcd_busy
//   lcd_busy    LCD_CTRL busy
//   lcd_done    LCD_CTRL end-of-WRITE pulse
//   seq_busy    high in every state except IDLE
//   seq_done    1-cycle pulse when the script completes
//   issued_cnt  legal commands issued in the current/last run (saturating)
//   skip_cnt    illegal entries skipped in the current/last run (saturating)
module lcd_cmd_sequencer #(
    parameter int unsigned CROM_AW  = 6,
    parameter int unsigned CMD_W    = 4,
    parameter int unsigned LAST_CMD = 11
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic               crom_rd,
    output logic [CROM_AW-1:0] crom_a,
    input  logic [4:0]         crom_q,
    output logic [CMD_W-1:0]   lcd_cmd,
    output logic               lcd_valid,
    input  logic               lcd_busy,
    input  logic               lcd_done,
    output logic               seq_busy,
    output logic               seq_done,
    output logic [CROM_AW:0]   issued_cnt,
    output logic [CROM_AW:0]   skip_cnt
);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StLatch,
        StIssue,
        StSettle,
        StWaitD,
        StNext,
        StFin
    } state_e;

    localparam logic [CROM_AW:0]   CntOne = {{CROM_AW{1'b0}}, 1'b1};
    localparam logic [CROM_AW-1:0] PtrOne = {{(CROM_AW-1){1'b0}}, 1'b1};

    state_e             state_q, state_d;
    logic [CROM_AW-1:0] ptr_q, ptr_d;
    logic [3:0]         cur_cmd_q, cur_cmd_d;
    logic               cur_last_q, cur_last_d;
    logic [CMD_W-1:0]   lcd_cmd_q, lcd_cmd_d;
    logic [CROM_AW:0]   issued_q, issued_d;
    logic [CROM_AW:0]   skip_q, skip_d;
    logic               crom_illegal;

    assign crom_illegal = 32'(crom_q[3:0]) > LAST_CMD;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            ptr_q      <= '0;
            cur_cmd_q  <= '0;
            cur_last_q <= 1'b0;
            lcd_cmd_q  <= '0;
            issued_q   <= '0;
            skip_q     <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            cur_cmd_q  <= cur_cmd_d;
            cur_last_q <= cur_last_d;
            lcd_cmd_q  <= lcd_cmd_d;
            issued_q   <= issued_d;
            skip_q     <= skip_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        cur_cmd_d  = cur_cmd_q;
        cur_last_d = cur_last_q;
        lcd_cmd_d  = lcd_cmd_q;
        issued_d   = issued_q;
        skip_d     = skip_q;
        crom_rd    = 1'b0;
        lcd_valid  = 1'b0;
        seq_done   = 1'b0;

        case (state_q)
            StIdle: begin
                if (start) begin
                    issued_d = '0;
                    skip_d   = '0;
                    ptr_d    = '0;
                    state_d  = StFetch;
                end
            end
            StFetch: begin
                crom_rd = 1'b1;
                state_d = StLatch;
            end
            StLatch: begin
                // crom_q is valid now; the legality decision uses it directly.
                cur_cmd_d  = crom_q[3:0];
                cur_last_d = crom_q[4];
                if (crom_illegal) begin
                    if (!(&skip_q)) begin
                        skip_d = skip_q + CntOne;
                    end
                    state_d = StNext;
                end else begin
                    lcd_cmd_d = CMD_W'(crom_q[3:0]);
                    state_d   = StIssue;
                end
            end
            StIssue: begin
                // Waiting here also absorbs the post-reset ROM load of LCD_CTRL.
                lcd_valid = !lcd_busy;
                if (!lcd_busy) begin
                    if (!(&issued_q)) begin
                        issued_d = issued_q + CntOne;
                    end
                    state_d = StSettle;
                end
            end
            StSettle: begin
                // Gap cycle so lcd_busy can reflect the command just accepted.
                state_d = (cur_cmd_q == 4'd0) ? StWaitD : StNext;
            end
            StWaitD: begin
                if (lcd_done) begin
                    state_d = StNext;
                end
            end
            StNext: begin
                // Stop at the last flag or at the top of the ROM; never wrap.
                if (cur_last_q || (&ptr_q)) begin
                    state_d = StFin;
                end else begin
                    ptr_d   = ptr_q + PtrOne;
                    state_d = StFetch;
                end
            end
            StFin: begin
                seq_done = 1'b1;
                state_d  = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign crom_a     = ptr_q;
    assign lcd_cmd    = lcd_cmd_q;
    assign seq_busy   = (state_q != StIdle);
    assign issued_cnt = issued_q;
    assign skip_cnt   = skip_q;

endmodule

// File: tb/tb_lcd_cmd_sequencer.sv
// tb_lcd_cmd_sequencer
//   Bench for lcd_cmd_sequencer. A registered CROM model supplies the script. A small
//   LCD responder holds lcd_busy for wr_len cycles after each accepted WRITE and then
//   pulses lcd_done. Expected commands are pushed to a scoreboard queue when a run
//   starts. They are popped at every lcd_valid. Table-driven scripts cover the main
//   function, and hand-written sequences cover busy gating, write wait, skipping, full
//   ROM, reset abort and start filtering.
module tb_lcd_cmd_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       crom_rd;
    logic [5:0] crom_a;
    logic [4:0] crom_q = 5'd0;
    logic [3:0] lcd_cmd;
    logic       lcd_valid;
    logic       lcd_busy;
    logic       lcd_done;
    logic       seq_busy;
    logic       seq_done;
    logic [6:0] issued_cnt;
    logic [6:0] skip_cnt;

    logic       host_busy;
    logic       wr_busy;
    int         wr_len;
    int         wr_left;

    int checks = 0;
    int failures = 0;

    logic [4:0] mem [64];
    logic [3:0] sb [$];

    int cyc = 0;
    int valid_count = 0;
    int done_count = 0;
    int rd_count = 0;
    int first_valid_cyc = -1;
    int done_cyc = 0;
    int fin_cyc = 0;
    int fin_addr = 0;
    logic prev_valid = 1'b0;
    logic last_valid_write = 1'b0;

    assign lcd_busy = host_busy | wr_busy;

    lcd_cmd_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .crom_rd    (crom_rd),
        .crom_a     (crom_a),
        .crom_q     (crom_q),
        .lcd_cmd    (lcd_cmd),
        .lcd_valid  (lcd_valid),
        .lcd_busy   (lcd_busy),
        .lcd_done   (lcd_done),
        .seq_busy   (seq_busy),
        .seq_done   (seq_done),
        .issued_cnt (issued_cnt),
        .skip_cnt   (skip_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (crom_rd) crom_q <= mem[crom_a];
    end

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // LCD responder: busy for wr_len cycles after a WRITE is accepted, then lcd_done.
    initial begin
        wr_busy  = 1'b0;
        lcd_done = 1'b0;
        wr_left  = 0;
        forever begin
            @(posedge clk);
            #1;
            lcd_done = 1'b0;
            if (!reset) begin
                wr_left = 0;
                wr_busy = 1'b0;
            end else if (wr_left > 0) begin
                wr_left--;
                if (wr_left == 0) begin
                    wr_busy  = 1'b0;
                    lcd_done = 1'b1;
                end
            end else if (last_valid_write) begin
                wr_busy = 1'b1;
                wr_left = wr_len;
            end
        end
    end

    // Output monitor and scoreboard consumer, sampled on the falling edge.
    always @(negedge clk) begin
        if (reset) begin
            if (lcd_valid) begin
                valid_count++;
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
                check("valid_while_busy", lcd_busy, 0);
                check("valid_back_to_back", prev_valid, 0);
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_issue: got cmd %0d expected no command", lcd_cmd);
                end else begin
                    check("issue_cmd", lcd_cmd, sb.pop_front());
                end
            end
            if (crom_rd) rd_count++;
            if (seq_done) begin
                done_count++;
                fin_cyc  = cyc;
                fin_addr = crom_a;
            end
            if (lcd_done) done_cyc = cyc;
            prev_valid       = lcd_valid;
            last_valid_write = lcd_valid && (lcd_cmd == 4'd0);
        end else begin
            prev_valid       = 1'b0;
            last_valid_write = 1'b0;
        end
    end

    // Reference model of the script walk: legal codes in order, stop at last or entry 63.
    task automatic build_expect();
        for (int i = 0; i < 64; i++) begin
            if (int'(mem[i][3:0]) <= 11) sb.push_back(mem[i][3:0]);
            if (mem[i][4]) break;
        end
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int d0 = done_count;
        bit seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #1;
            if (done_count != d0) begin
                seen = 1'b1;
                break;
            end
        end
        check("done_within_budget", seen, 1);
        repeat (3) @(posedge clk);
        #1;
        check("done_once", done_count - d0, 1);
        check("sb_drained", sb.size(), 0);
    endtask

    task automatic run_script(input int budget);
        build_expect();
        pulse_start();
        wait_done(budget);
    endtask

    typedef struct packed {
        logic [3:0][4:0] ent;
        int              exp_issued;
        int              exp_skip;
    } vec_t;

    vec_t vecs [6];

    initial begin
        #400000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int rel;
        int busy_fall;
        int v0;
        int r0;
        bit seen;

        vecs[0] = '{ent: {5'h00, 5'h1B, 5'h02, 5'h01}, exp_issued: 3, exp_skip: 0};
        vecs[1] = '{ent: {5'h00, 5'h00, 5'h00, 5'h1C}, exp_issued: 0, exp_skip: 1};
        vecs[2] = '{ent: {5'h00, 5'h00, 5'h15, 5'h00}, exp_issued: 2, exp_skip: 0};
        vecs[3] = '{ent: {5'h00, 5'h1D, 5'h08, 5'h0F}, exp_issued: 1, exp_skip: 2};
        vecs[4] = '{ent: {5'h00, 5'h00, 5'h00, 5'h10}, exp_issued: 1, exp_skip: 0};
        vecs[5] = '{ent: {5'h16, 5'h0A, 5'h0C, 5'h0B}, exp_issued: 3, exp_skip: 1};

        for (int i = 0; i < 64; i++) mem[i] = 5'h10;
        reset     = 1'b0;
        start     = 1'b0;
        host_busy = 1'b1;
        wr_len    = 3;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_crom_rd", crom_rd, 0);
        check("rst_crom_a", crom_a, 0);
        check("rst_lcd_valid", lcd_valid, 0);
        check("rst_lcd_cmd", lcd_cmd, 0);
        check("rst_seq_busy", seq_busy, 0);
        check("rst_seq_done", seq_done, 0);
        check("rst_issued", issued_cnt, 0);
        check("rst_skip", skip_cnt, 0);

        // Busy gating after reset: script {1, last:9}, busy for 70 cycles
        mem[0] = 5'h01;
        mem[1] = 5'h19;
        reset  = 1'b1;
        rel    = cyc;
        @(posedge clk);
        #1;
        build_expect();
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        while (cyc - rel < 70) begin
            @(posedge clk);
            #1;
        end
        check("busy_no_early_valid", valid_count, 0);
        check("busy_parked", seq_busy, 1);
        host_busy = 1'b0;
        busy_fall = cyc;
        wait_done(100);
        check("busy_first_valid_cyc", first_valid_cyc, busy_fall);
        check("busy_issued", issued_cnt, 2);
        check("busy_skip", skip_cnt, 0);

        // Table-driven scripts
        for (int v = 0; v < 6; v++) begin
            for (int i = 0; i < 4; i++) mem[i] = vecs[v].ent[i];
            run_script(120);
            check($sformatf("vec%0d_issued", v), issued_cnt, vecs[v].exp_issued);
            check($sformatf("vec%0d_skip", v), skip_cnt, vecs[v].exp_skip);
            check($sformatf("vec%0d_idle", v), seq_busy, 0);
        end

        // Write wait: {5, last:0}, busy 64 cycles after the WRITE is accepted
        wr_len = 64;
        mem[0] = 5'h05;
        mem[1] = 5'h10;
        v0     = valid_count;
        run_script(200);
        check("wr_done_to_fin", fin_cyc - done_cyc, 2);
        check("wr_valid_count", valid_count - v0, 2);
        check("wr_issued", issued_cnt, 2);
        wr_len = 3;

        // Illegal codes: {3, 14, 15, last:4}
        mem[0] = 5'h03;
        mem[1] = 5'h0E;
        mem[2] = 5'h0F;
        mem[3] = 5'h14;
        v0     = valid_count;
        run_script(120);
        check("ill_valid_count", valid_count - v0, 2);
        check("ill_skip", skip_cnt, 2);
        check("ill_issued", issued_cnt, 2);

        // Full ROM with no last flag: 64 x cmd 2
        for (int i = 0; i < 64; i++) mem[i] = 5'h02;
        r0 = rd_count;
        run_script(500);
        check("full_issued", issued_cnt, 64);
        check("full_reads", rd_count - r0, 64);
        check("full_fin_addr", fin_addr, 63);
        check("full_addr_hold", crom_a, 63);

        // Reset abort during WAIT_D: {7, 0, last:2}
        wr_len = 40;
        mem[0] = 5'h07;
        mem[1] = 5'h00;
        mem[2] = 5'h12;
        build_expect();
        pulse_start();
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            if (wr_busy) begin
                seen = 1'b1;
                break;
            end
        end
        check("abort_write_accepted", seen, 1);
        repeat (3) @(posedge clk);
        #1;
        check("abort_pre_busy", seq_busy, 1);
        #2 reset = 1'b0;
        #1;
        check("abort_seq_busy", seq_busy, 0);
        check("abort_lcd_cmd", lcd_cmd, 0);
        check("abort_crom_a", crom_a, 0);
        check("abort_issued", issued_cnt, 0);
        check("abort_lcd_valid", lcd_valid, 0);
        sb.delete();
        @(posedge clk);
        #1 reset = 1'b1;
        v0 = valid_count;
        repeat (20) @(posedge clk);
        #1;
        check("abort_idle", seq_busy, 0);
        check("abort_no_valid", valid_count - v0, 0);
        wr_len = 3;

        // Start during run, start coincident with FIN, then start in the next IDLE cycle
        mem[0] = 5'h01;
        mem[1] = 5'h02;
        mem[2] = 5'h13;
        build_expect();
        pulse_start();
        repeat (5) @(posedge clk);
        pulse_start();
        check("mid_start_busy", seq_busy, 1);
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1;
            if (seq_done) begin
                seen = 1'b1;
                break;
            end
        end
        check("fin_reached", seen, 1);
        start = 1'b1;
        @(posedge clk);
        #1;
        check("fin_start_ignored", seq_busy, 0);
        check("fin_issued_hold", issued_cnt, 3);
        check("fin_sb_drained", sb.size(), 0);
        build_expect();
        @(posedge clk);
        #1 start = 1'b0;
        check("rerun_busy", seq_busy, 1);
        check("rerun_issued_clear", issued_cnt, 0);
        check("rerun_crom_a", crom_a, 0);
        wait_done(60);
        check("rerun_issued", issued_cnt, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
